router_pkt_reader: RTL

ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

---
 rtl/router_pkt_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/router_pkt_reader.sv
// ============================================================================
// Module   : router_pkt_reader
// Purpose  : Reads packets from a FIFO with a fixed read latency, tags
//            header/parity bytes, and checks parity. A 4-entry buffer feeds
//            the downstream port. A stall watchdog issues a soft reset.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module router_pkt_reader #(
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       empty,
  input  logic [7:0] data_in,
  output logic       read_enb,
  output logic       soft_reset,
  input  logic       dest_ready,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_sop,
  output logic       pkt_eop,
  output logic       parity_err,
  output logic       busy
);

  localparam logic [2:0] BUF_DEPTH = 3'd4;
  localparam logic [5:0] STALL_MAX = 6'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PARITY  = 2'd3
  } state_t;

  state_t            state;
  logic [RD_LAT-1:0] flight;
  logic [10:0]       buf_mem [4];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [2:0]        count;
  logic [5:0]        stall_cnt;
  logic              sr_hold;
  logic [5:0]        len_left;
  logic [7:0]        parity;

  logic [2:0]        inflight_cnt;
  logic [2:0]        credit;
  logic              capture;
  logic              pop;
  logic              stall;
  logic              timeout;
  logic              is_header;
  logic              is_payload;
  logic              is_parity;
  logic [10:0]       head;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + {2'b00, flight[i]};
    end
  end

  assign credit   = BUF_DEPTH - count - inflight_cnt;
  // Reads pause while soft_reset is high and for one cycle after it.
  assign read_enb = resetn && !empty && (credit != 3'd0) && !soft_reset && !sr_hold;

  assign capture  = flight[RD_LAT-1];
  assign pop      = pkt_valid && dest_ready;
  assign stall    = pkt_valid && !dest_ready;
  assign timeout  = stall && (stall_cnt == STALL_MAX);

  // HEADER is transient: a byte arriving there is classified by len_left.
  assign is_header  = (state == IDLE);
  assign is_payload = ((state == HEADER) || (state == PAYLOAD)) && (len_left != 6'd0);
  assign is_parity  = !is_header && !is_payload;

  assign head       = buf_mem[rd_ptr];
  assign pkt_valid  = (count != 3'd0);
  assign pkt_data   = pkt_valid ? head[7:0] : 8'h00;
  assign pkt_sop    = pkt_valid && head[8];
  assign pkt_eop    = pkt_valid && head[9];
  assign parity_err = pkt_valid && head[10];
  assign busy       = (state != IDLE) || (count != 3'd0) || (flight != '0);

  // Entry layout: {err, eop, sop, data}.
  always_ff @(posedge clock) begin
    if (capture && !timeout) begin
      buf_mem[wr_ptr] <= {is_parity && (parity != data_in), is_parity, is_header, data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      flight     <= '0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      stall_cnt  <= 6'd0;
      soft_reset <= 1'b0;
      sr_hold    <= 1'b0;
      len_left   <= 6'd0;
      parity     <= 8'h00;
    end else begin
      soft_reset <= timeout;
      sr_hold    <= soft_reset;
      if (timeout) begin
        state     <= IDLE;
        flight    <= '0;
        wr_ptr    <= 2'd0;
        rd_ptr    <= 2'd0;
        count     <= 3'd0;
        stall_cnt <= 6'd0;
        len_left  <= 6'd0;
        parity    <= 8'h00;
      end else begin
        flight    <= RD_LAT'({flight, read_enb});
        stall_cnt <= stall ? stall_cnt + 6'd1 : 6'd0;
        if (capture) begin
          wr_ptr <= wr_ptr + 2'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 2'd1;
        end
        count <= count + {2'b00, capture} - {2'b00, pop};

        if (capture) begin
          if (is_header) begin
            len_left <= data_in[7:2];
            parity   <= data_in;
            state    <= HEADER;
          end else if (is_payload) begin
            len_left <= len_left - 6'd1;
            parity   <= parity ^ data_in;
            state    <= (len_left == 6'd1) ? PARITY : PAYLOAD;
          end else begin
            parity   <= 8'h00;
            state    <= IDLE;
          end
        end else if (state == HEADER) begin
          state <= (len_left != 6'd0) ? PAYLOAD : PARITY;
        end
      end
    end
  end

endmodule

`default_nettype wire
